// File: rtl/mm_cfg_pkg.sv
// Shared types and constants for the matmul descriptor checker.
package mm_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SIZE,
    ST_OVL,
    ST_RESP
  } state_t;

  localparam int ERR_SIZE = 0;
  localparam int ERR_DIV  = 1;
  localparam int ERR_OVF  = 2;
  localparam int ERR_OVL  = 3;

  localparam logic [2:0] PAIR_A_B    = 3'd0;
  localparam logic [2:0] PAIR_A_C    = 3'd1;
  localparam logic [2:0] PAIR_B_C    = 3'd2;
  localparam logic [2:0] PAIR_A_BIAS = 3'd3;
  localparam logic [2:0] PAIR_B_BIAS = 3'd4;
  localparam logic [2:0] PAIR_C_BIAS = 3'd5;
  localparam logic [2:0] PAIR_FINAL  = 3'd6;
  localparam logic [2:0] PAIR_NONE   = 3'd7;

  // Region ends are kept one bit wider than either operand so base+size never wraps.
  function automatic int end_w(input int addr_w, input int dim_w);
    return ((addr_w > 2 * dim_w) ? addr_w : 2 * dim_w) + 1;
  endfunction

endpackage

// File: rtl/mm_region_overlap.sv
// Half-open interval intersection test on unwrapped region ends.
module mm_region_overlap #(
  parameter int END_W = 11
) (
  input  logic [END_W-1:0] b1,
  input  logic [END_W-1:0] e1,
  input  logic [END_W-1:0] b2,
  input  logic [END_W-1:0] e2,
  output logic             overlap
);

  assign overlap = (b1 < e2) && (b2 < e1);

endmodule

// File: rtl/mm_cfg_checker.sv
// Multi-cycle matmul descriptor checker: size/divisibility/bounds checks, then
// one region-pair overlap test per cycle, with a fixed-latency handshaked result.
module mm_cfg_checker
  import mm_cfg_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int DIM_W     = 4,
  parameter int TILE      = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [DIM_W-1:0]     M,
  input  logic [DIM_W-1:0]     N,
  input  logic [DIM_W-1:0]     K,
  input  logic [ADDR_W-1:0]    base_in1,
  input  logic [ADDR_W-1:0]    base_in2,
  input  logic [ADDR_W-1:0]    base_out,
  input  logic [ADDR_W-1:0]    base_bias,
  input  logic                 bias_en,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic                 err_found,
  output logic [3:0]           err_code,
  output logic [2:0]           err_pair,
  output logic [ERR_CNT_W-1:0] err_count,
  input  logic                 cnt_clr
);

  localparam int END_W = end_w(ADDR_W, DIM_W);
  localparam int P_W   = 2 * DIM_W;
  localparam int LOG2T = $clog2(TILE);
  localparam logic [DIM_W-1:0] TILE_D  = DIM_W'(TILE);
  localparam logic [END_W-1:0] MEM_END = END_W'(1) << ADDR_W;

  state_t state_q, state_d;

  logic [DIM_W-1:0]     m_q, n_q, k_q;
  logic [ADDR_W-1:0]    a_q, b_q, c_q, bias_q;
  logic                 bias_en_q;
  logic [END_W-1:0]     end_a_q, end_b_q, end_c_q, end_bias_q;
  logic [2:0]           pair_idx_q;
  logic [3:0]           err_code_q;
  logic [2:0]           err_pair_q;
  logic [ERR_CNT_W-1:0] err_count_q;

  logic                 accept;
  logic                 size_err, div_err, ovf_err;
  logic [P_W-1:0]       sz_mn, sz_nk, sz_mk;
  logic [END_W-1:0]     end_a_d, end_b_d, end_c_d, end_bias_d;
  logic [END_W-1:0]     ov_b1, ov_e1, ov_b2, ov_e2;
  logic                 pair_active, pair_overlap, pair_hit;
  logic                 resp_entry;

  assign accept     = cfg_valid && cfg_ready;
  assign resp_entry = (state_q == ST_OVL) && (pair_idx_q == PAIR_FINAL);

  assign sz_mn      = P_W'(m_q) * P_W'(n_q);
  assign sz_nk      = P_W'(n_q) * P_W'(k_q);
  assign sz_mk      = P_W'(m_q) * P_W'(k_q);
  assign end_a_d    = END_W'(a_q) + END_W'(sz_mn);
  assign end_b_d    = END_W'(b_q) + END_W'(sz_nk);
  assign end_c_d    = END_W'(c_q) + END_W'(sz_mk);
  assign end_bias_d = END_W'(bias_q) + END_W'(sz_mk);

  assign size_err = (m_q < TILE_D) || (n_q < TILE_D) || (k_q < TILE_D);
  assign div_err  = (|m_q[LOG2T-1:0]) || (|n_q[LOG2T-1:0]) || (|k_q[LOG2T-1:0]);
  assign ovf_err  = (end_a_d > MEM_END) || (end_b_d > MEM_END) || (end_c_d > MEM_END)
                 || (bias_en_q && (end_bias_d > MEM_END));

  always_comb begin
    ov_b1       = '0;
    ov_e1       = '0;
    ov_b2       = '0;
    ov_e2       = '0;
    pair_active = 1'b1;
    case (pair_idx_q)
      PAIR_A_B:    begin ov_b1 = END_W'(a_q); ov_e1 = end_a_q; ov_b2 = END_W'(b_q);    ov_e2 = end_b_q;    end
      PAIR_A_C:    begin ov_b1 = END_W'(a_q); ov_e1 = end_a_q; ov_b2 = END_W'(c_q);    ov_e2 = end_c_q;    end
      PAIR_B_C:    begin ov_b1 = END_W'(b_q); ov_e1 = end_b_q; ov_b2 = END_W'(c_q);    ov_e2 = end_c_q;    end
      PAIR_A_BIAS: begin ov_b1 = END_W'(a_q); ov_e1 = end_a_q; ov_b2 = END_W'(bias_q); ov_e2 = end_bias_q; end
      PAIR_B_BIAS: begin ov_b1 = END_W'(b_q); ov_e1 = end_b_q; ov_b2 = END_W'(bias_q); ov_e2 = end_bias_q; end
      PAIR_C_BIAS: begin ov_b1 = END_W'(c_q); ov_e1 = end_c_q; ov_b2 = END_W'(bias_q); ov_e2 = end_bias_q; end
      default:     pair_active = 1'b0;
    endcase
    if ((pair_idx_q >= PAIR_A_BIAS) && !bias_en_q) pair_active = 1'b0;
  end

  mm_region_overlap #(.END_W(END_W)) u_ovl (
    .b1      (ov_b1),
    .e1      (ov_e1),
    .b2      (ov_b2),
    .e2      (ov_e2),
    .overlap (pair_overlap)
  );

  assign pair_hit = (state_q == ST_OVL) && pair_active && pair_overlap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // OVL runs one extra slot (PAIR_FINAL) so the last pair result is registered
  // before RESP entry, keeping the response at a fixed eight cycles after accept.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (cfg_valid)                  state_d = ST_SIZE;
      ST_SIZE:                                 state_d = ST_OVL;
      ST_OVL:  if (pair_idx_q == PAIR_FINAL)   state_d = ST_RESP;
      ST_RESP: if (res_ready)                  state_d = ST_IDLE;
      default:                                 state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q         <= '0;
      n_q         <= '0;
      k_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      bias_q      <= '0;
      bias_en_q   <= 1'b0;
      end_a_q     <= '0;
      end_b_q     <= '0;
      end_c_q     <= '0;
      end_bias_q  <= '0;
      pair_idx_q  <= '0;
      err_code_q  <= '0;
      err_pair_q  <= PAIR_NONE;
      err_count_q <= '0;
    end else begin
      if (accept) begin
        m_q        <= M;
        n_q        <= N;
        k_q        <= K;
        a_q        <= base_in1;
        b_q        <= base_in2;
        c_q        <= base_out;
        bias_q     <= base_bias;
        bias_en_q  <= bias_en;
        pair_idx_q <= '0;
        err_code_q <= '0;
        err_pair_q <= PAIR_NONE;
      end
      if (state_q == ST_SIZE) begin
        end_a_q              <= end_a_d;
        end_b_q              <= end_b_d;
        end_c_q              <= end_c_d;
        end_bias_q           <= end_bias_d;
        err_code_q[ERR_SIZE] <= size_err;
        err_code_q[ERR_DIV]  <= div_err;
        err_code_q[ERR_OVF]  <= ovf_err;
      end
      if (state_q == ST_OVL) begin
        pair_idx_q <= pair_idx_q + 3'd1;
        if (pair_hit) begin
          err_code_q[ERR_OVL] <= 1'b1;
          if (err_pair_q == PAIR_NONE) err_pair_q <= pair_idx_q;
        end
      end
      if (cnt_clr)
        err_count_q <= '0;
      else if (resp_entry && (|err_code_q) && (err_count_q != '1))
        err_count_q <= err_count_q + 1'b1;
    end
  end

  assign cfg_ready = (state_q == ST_IDLE);
  assign res_valid = (state_q == ST_RESP);
  assign err_found = |err_code_q;
  assign err_code  = err_code_q;
  assign err_pair  = err_pair_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_mm_cfg_checker.sv
// Directed self-checking bench for mm_cfg_checker (ADDR_W=10, DIM_W=4, TILE=4).
module tb_mm_cfg_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [3:0] M = '0, N = '0, K = '0;
  logic [9:0] base_in1 = '0, base_in2 = '0, base_out = '0, base_bias = '0;
  logic       bias_en = 1'b0;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic       err_found;
  logic [3:0] err_code;
  logic [2:0] err_pair;
  logic [7:0] err_count;
  logic       cnt_clr = 1'b0;

  int errors = 0;
  int checks = 0;
  int lat;
  logic busy_ok;

  always #5 clk = ~clk;

  mm_cfg_checker #(.ADDR_W(10), .DIM_W(4), .TILE(4), .ERR_CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .M         (M),
    .N         (N),
    .K         (K),
    .base_in1  (base_in1),
    .base_in2  (base_in2),
    .base_out  (base_out),
    .base_bias (base_bias),
    .bias_en   (bias_en),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .err_found (err_found),
    .err_code  (err_code),
    .err_pair  (err_pair),
    .err_count (err_count),
    .cnt_clr   (cnt_clr)
  );

  // Accepts one descriptor, scrambles the inputs afterwards, and measures the
  // accept-to-res_valid distance (20 means the bound expired).
  task automatic do_job(input logic [3:0] m, n, k, input logic [9:0] a, b, c, bi,
                        input logic ben, input logic clr_at_end,
                        output int lat_o, output logic busy_o);
    M = m; N = n; K = k;
    base_in1 = a; base_in2 = b; base_out = c; base_bias = bi; bias_en = ben;
    cfg_valid = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    M = 4'h1; N = 4'h3; K = 4'h2;
    base_in1 = 10'h3FF; base_in2 = 10'h3FF; base_out = 10'h3FF; base_bias = 10'h3FF;
    bias_en = ~ben;
    lat_o = 0;
    busy_o = 1'b1;
    while (!res_valid && lat_o < 20) begin
      if (cfg_ready) busy_o = 1'b0;
      if (clr_at_end && lat_o == 7) cnt_clr = 1'b1;
      @(posedge clk); #1;
      lat_o++;
      cnt_clr = 1'b0;
    end
  endtask

  task automatic release_job();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready got=%b exp=1", cfg_ready); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
    checks++; if (err_found !== 1'b0) begin errors++; $display("FAIL reset_err_found got=%b exp=0", err_found); end
    checks++; if (err_code !== 4'b0000) begin errors++; $display("FAIL reset_err_code got=%b exp=0000", err_code); end
    checks++; if (err_pair !== 3'd7) begin errors++; $display("FAIL reset_err_pair got=%0d exp=7", err_pair); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count got=%0d exp=0", err_count); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    do_job(4, 4, 4, 0, 16, 32, 0, 1'b0, 1'b0, lat, busy_ok);
    checks++; if (lat !== 8) begin errors++; $display("FAIL basic_latency got=%0d exp=8", lat); end
    checks++; if (busy_ok !== 1'b1) begin errors++; $display("FAIL basic_cfg_ready_low got=%b exp=1", busy_ok); end
    checks++; if (err_code !== 4'b0000) begin errors++; $display("FAIL basic_err_code got=%b exp=0000", err_code); end
    checks++; if (err_pair !== 3'd7) begin errors++; $display("FAIL basic_err_pair got=%0d exp=7", err_pair); end
    checks++; if (err_found !== 1'b0) begin errors++; $display("FAIL basic_err_found got=%b exp=0", err_found); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL basic_err_count got=%0d exp=0", err_count); end
    release_job();
    checks++; if (cfg_ready !== 1'b1 || res_valid !== 1'b0)
      begin errors++; $display("FAIL basic_idle_after got=%b%b exp=10", cfg_ready, res_valid); end
  endtask

  task automatic test_overlap();
    do_job(4, 4, 4, 0, 8, 32, 0, 1'b0, 1'b0, lat, busy_ok);
    checks++; if (lat !== 8) begin errors++; $display("FAIL ovl_ab_latency got=%0d exp=8", lat); end
    checks++; if (err_code !== 4'b1000) begin errors++; $display("FAIL ovl_ab_code got=%b exp=1000", err_code); end
    checks++; if (err_pair !== 3'd0) begin errors++; $display("FAIL ovl_ab_pair got=%0d exp=0", err_pair); end
    checks++; if (err_found !== 1'b1) begin errors++; $display("FAIL ovl_ab_found got=%b exp=1", err_found); end
    checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL ovl_ab_count got=%0d exp=1", err_count); end
    release_job();
    do_job(4, 4, 4, 0, 16, 32, 40, 1'b1, 1'b0, lat, busy_ok);
    checks++; if (err_code !== 4'b1000) begin errors++; $display("FAIL ovl_cbias_code got=%b exp=1000", err_code); end
    checks++; if (err_pair !== 3'd5) begin errors++; $display("FAIL ovl_cbias_pair got=%0d exp=5", err_pair); end
    checks++; if (err_count !== 8'd2) begin errors++; $display("FAIL ovl_cbias_count got=%0d exp=2", err_count); end
    release_job();
    // bias region sits on top of A but is disabled
    do_job(4, 4, 4, 0, 16, 32, 0, 1'b0, 1'b0, lat, busy_ok);
    checks++; if (err_code !== 4'b0000 || err_pair !== 3'd7)
      begin errors++; $display("FAIL ovl_masked got=%b/%0d exp=0000/7", err_code, err_pair); end
    checks++; if (err_count !== 8'd2) begin errors++; $display("FAIL ovl_masked_count got=%0d exp=2", err_count); end
    release_job();
  endtask

  task automatic test_ovf();
    do_job(4, 4, 4, 0, 16, 1016, 0, 1'b0, 1'b0, lat, busy_ok);
    checks++; if (err_code !== 4'b0100) begin errors++; $display("FAIL ovf_code got=%b exp=0100", err_code); end
    checks++; if (err_pair !== 3'd7) begin errors++; $display("FAIL ovf_pair got=%0d exp=7", err_pair); end
    checks++; if (err_count !== 8'd3) begin errors++; $display("FAIL ovf_count got=%0d exp=3", err_count); end
    release_job();
    do_job(4, 4, 4, 0, 16, 1008, 0, 1'b0, 1'b0, lat, busy_ok);
    checks++; if (err_code !== 4'b0000) begin errors++; $display("FAIL ovf_edge_code got=%b exp=0000", err_code); end
    checks++; if (err_count !== 8'd3) begin errors++; $display("FAIL ovf_edge_count got=%0d exp=3", err_count); end
    release_job();
  endtask

  task automatic test_dims();
    do_job(2, 4, 4, 0, 16, 32, 0, 1'b0, 1'b0, lat, busy_ok);
    checks++; if (err_code !== 4'b0011) begin errors++; $display("FAIL dim_m2_code got=%b exp=0011", err_code); end
    checks++; if (lat !== 8) begin errors++; $display("FAIL dim_m2_latency got=%0d exp=8", lat); end
    checks++; if (err_count !== 8'd4) begin errors++; $display("FAIL dim_m2_count got=%0d exp=4", err_count); end
    release_job();
    do_job(6, 4, 4, 0, 64, 128, 0, 1'b0, 1'b0, lat, busy_ok);
    checks++; if (err_code !== 4'b0010) begin errors++; $display("FAIL dim_m6_code got=%b exp=0010", err_code); end
    checks++; if (err_count !== 8'd5) begin errors++; $display("FAIL dim_m6_count got=%0d exp=5", err_count); end
    release_job();
    do_job(8, 8, 8, 0, 64, 128, 0, 1'b0, 1'b0, lat, busy_ok);
    checks++; if (err_code !== 4'b0000 || err_pair !== 3'd7)
      begin errors++; $display("FAIL dim_888_result got=%b/%0d exp=0000/7", err_code, err_pair); end
    checks++; if (err_count !== 8'd5) begin errors++; $display("FAIL dim_888_count got=%0d exp=5", err_count); end
    release_job();
  endtask

  task automatic test_back_to_back();
    do_job(4, 4, 4, 0, 8, 32, 0, 1'b0, 1'b0, lat, busy_ok);
    checks++; if (err_count !== 8'd6) begin errors++; $display("FAIL stall_count got=%0d exp=6", err_count); end
    for (int i = 0; i < 5; i++) begin
      M = 4'd8; N = 4'd8; K = 4'd8;
      base_in1 = 10'd0; base_in2 = 10'd512; base_out = 10'd256;
      cfg_valid = (i % 2 == 0);
      @(posedge clk); #1;
      checks++;
      if (res_valid !== 1'b1 || err_code !== 4'b1000 || err_pair !== 3'd0 || cfg_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold cyc=%0d got v=%b code=%b pair=%0d rdy=%b exp v=1 code=1000 pair=0 rdy=0",
                 i, res_valid, err_code, err_pair, cfg_ready);
      end
    end
    cfg_valid = 1'b0;
    release_job();
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL stall_release got=%b exp=1", cfg_ready); end
    do_job(4, 4, 4, 0, 16, 32, 0, 1'b0, 1'b0, lat, busy_ok);
    checks++; if (lat !== 8 || err_code !== 4'b0000)
      begin errors++; $display("FAIL b2b_job got lat=%0d code=%b exp lat=8 code=0000", lat, err_code); end
    release_job();
  endtask

  task automatic test_saturate();
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL clr_idle got=%0d exp=0", err_count); end
    for (int i = 0; i < 255; i++) begin
      do_job(4, 4, 4, 0, 8, 32, 0, 1'b0, 1'b0, lat, busy_ok);
      release_job();
    end
    checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL sat_255 got=%0d exp=255", err_count); end
    do_job(4, 4, 4, 0, 8, 32, 0, 1'b0, 1'b0, lat, busy_ok);
    checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL sat_256 got=%0d exp=255", err_count); end
    release_job();
    do_job(4, 4, 4, 0, 8, 32, 0, 1'b0, 1'b1, lat, busy_ok);
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL clr_wins got=%0d exp=0", err_count); end
    checks++; if (err_code !== 4'b1000) begin errors++; $display("FAIL clr_wins_code got=%b exp=1000", err_code); end
    release_job();
  endtask

  task automatic test_abort();
    logic seen;
    do_job(4, 4, 4, 0, 8, 32, 0, 1'b0, 1'b0, lat, busy_ok);
    checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL abort_pre_count got=%0d exp=1", err_count); end
    release_job();
    M = 4; N = 4; K = 4; base_in1 = 0; base_in2 = 8; base_out = 32; bias_en = 1'b0;
    cfg_valid = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (cfg_ready !== 1'b1 || res_valid !== 1'b0 || err_code !== 4'b0000 || err_pair !== 3'd7 || err_count !== 8'd0) begin
      errors++;
      $display("FAIL abort_values got rdy=%b v=%b code=%b pair=%0d cnt=%0d exp 1 0 0000 7 0",
               cfg_ready, res_valid, err_code, err_pair, err_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (res_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_result got=%b exp=0", seen); end
    do_job(4, 4, 4, 0, 16, 32, 0, 1'b0, 1'b0, lat, busy_ok);
    checks++; if (lat !== 8 || err_code !== 4'b0000 || err_pair !== 3'd7)
      begin errors++; $display("FAIL abort_next got lat=%0d code=%b pair=%0d exp 8 0000 7", lat, err_code, err_pair); end
    release_job();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overlap();
    test_ovf();
    test_dims();
    test_back_to_back();
    test_saturate();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
